spi_frame_rx: RTL and testbench

//  Front end of the SPI control path: brings raw ui_in SCK/CS_n/MOSI pins into the clk domain and

---
 rtl/spi_ctrl_pkg.sv | 33 +++
 rtl/spi_frame_rx_if.sv | 24 ++
 rtl/sync_ff.sv | 22 ++
 rtl/spi_frame_rx.sv | 120 ++++++++++++
 tb/tb_spi_frame_rx.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared SPI control-path constants: frame layout, error codes, receiver FSM encoding.
// Pure definitions; no latency or flow control involved.
package spi_ctrl_pkg;

  localparam int FRAME_BITS = 16;
  localparam int RW_BIT     = 15;
  localparam int ADDR_MSB   = 14;
  localparam int ADDR_LSB   = 8;
  localparam int DATA_MSB   = 7;
  localparam int DATA_LSB   = 0;

  localparam logic [1:0] ERR_SHORT = 2'b01;
  localparam logic [1:0] ERR_LONG  = 2'b10;

  localparam logic [1:0] ST_ARM   = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
  } frame_t;

  function automatic frame_t decode_frame(input logic [FRAME_BITS-1:0] w);
    frame_t f;
    f.rw   = w[RW_BIT];
    f.addr = w[ADDR_MSB:ADDR_LSB];
    f.data = w[DATA_MSB:DATA_LSB];
    return f;
  endfunction

endpackage

// File: rtl/spi_frame_rx_if.sv
// SPI pin bundle plus decoded-frame result bus for the SPI frame receiver.
// Pins are raw and asynchronous; result pulses carry no backpressure.
interface spi_frame_rx_if;
  logic       sck;
  logic       cs_n;
  logic       mosi;
  logic       frame_valid;
  logic       frame_rw;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;
  logic       frame_err;
  logic [1:0] err_code;
  logic [7:0] frame_cnt;

  modport master (
    output sck, cs_n, mosi,
    input  frame_valid, frame_rw, frame_addr, frame_data, frame_err, err_code, frame_cnt
  );

  modport slave (
    input  sck, cs_n, mosi,
    output frame_valid, frame_rw, frame_addr, frame_data, frame_err, err_code, frame_cnt
  );
endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous pin, with a selectable reset value.
// Latency DEPTH clk cycles; no backpressure.
module sync_ff #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= {DEPTH{RST_VAL}};
    else        chain <= {chain[DEPTH-2:0], d};
  end

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: syncs pins, assembles MSB-first frames, pulses valid/err on CS rise.
// Latency SYNC_STAGES+2 clk from CS high at the pin to the pulse; no backpressure (pulses are one-shot).
module spi_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = spi_ctrl_pkg::FRAME_BITS
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_frame_rx_if.slave  bus
);
  import spi_ctrl_pkg::*;

  localparam int CW     = $clog2(FRAME_BITS + 1);
  localparam int SETTLE = SYNC_STAGES + 2;
  localparam int AW     = $clog2(SETTLE + 1);

  logic sck_s, cs_s, mosi_s;
  logic sck_h, cs_h, mosi_h;
  logic sck_rise, cs_fall, cs_rise;

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .d(bus.sck), .q(sck_s));
  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(bus.cs_n), .q(cs_s));
  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(bus.mosi), .q(mosi_s));

  // Edge pulses are registered; mosi_h is delayed alongside so it lines up with sck_rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_h    <= 1'b0;
      cs_h     <= 1'b1;
      mosi_h   <= 1'b0;
      sck_rise <= 1'b0;
      cs_fall  <= 1'b0;
      cs_rise  <= 1'b0;
    end else begin
      sck_h    <= sck_s;
      cs_h     <= cs_s;
      mosi_h   <= mosi_s;
      sck_rise <= sck_s & ~sck_h;
      cs_fall  <= ~cs_s & cs_h;
      cs_rise  <= cs_s & ~cs_h;
    end
  end

  logic [1:0]            state;
  logic [AW-1:0]         arm_cnt;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [CW-1:0]         bit_cnt;
  logic                  ovf;
  logic                  valid_q, err_q;
  logic [1:0]            err_code_q;
  frame_t                frame_q;
  logic [7:0]            cnt_q;
  logic                  arm_done;

  // The sync chains reset to "idle" values, so ARM waits for the real pin level
  // to reach the edge detectors before trusting a high CS.
  assign arm_done = (arm_cnt == AW'(SETTLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ARM;
      arm_cnt    <= '0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      ovf        <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      frame_q    <= '0;
      cnt_q      <= 8'd0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        ST_ARM: begin
          if (!arm_done)                        arm_cnt <= arm_cnt + AW'(1);
          else if (cs_s && cs_h && !cs_fall)    state   <= ST_IDLE;
        end
        ST_IDLE: begin
          if (cs_fall) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
            ovf     <= 1'b0;
          end
        end
        ST_SHIFT: begin
          // cs_rise takes priority; a coincident sck edge is dropped
          if (cs_rise) begin
            state <= ST_IDLE;
            if (bit_cnt == CW'(FRAME_BITS) && !ovf) begin
              frame_q <= decode_frame(shift_reg);
              valid_q <= 1'b1;
              cnt_q   <= cnt_q + 8'd1;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ovf ? ERR_LONG : ERR_SHORT;
            end
          end else if (sck_rise) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_h};
            if (bit_cnt == CW'(FRAME_BITS)) ovf     <= 1'b1;
            else                            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: state <= ST_ARM;
      endcase
    end
  end

  assign bus.frame_valid = valid_q;
  assign bus.frame_err   = err_q;
  assign bus.err_code    = err_code_q;
  assign bus.frame_rw    = frame_q.rw;
  assign bus.frame_addr  = frame_q.addr;
  assign bus.frame_data  = frame_q.data;
  assign bus.frame_cnt   = cnt_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Randomized bench for spi_frame_rx: drives SPI transactions and compares every pulse against a frame-level model.
module tb_spi_frame_rx;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_frame_rx_if bus ();

  spi_frame_rx #(.SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    bit       is_err;
    bit       rw;
    bit [6:0] addr;
    bit [7:0] data;
    bit [1:0] code;
    bit [7:0] cnt;
  } ev_t;

  ev_t evq[$];
  int  both_viol = 0;
  int  b2b_viol  = 0;
  bit  prev_pulse = 1'b0;

  always @(posedge clk) begin
    #1;
    if (bus.frame_valid && bus.frame_err) both_viol++;
    if ((bus.frame_valid || bus.frame_err) && prev_pulse) b2b_viol++;
    prev_pulse = bus.frame_valid || bus.frame_err;
    if (bus.frame_valid || bus.frame_err)
      evq.push_back('{bus.frame_err, bus.frame_rw, bus.frame_addr, bus.frame_data,
                      bus.err_code, bus.frame_cnt});
  end

  // Frame-level model of what the outputs should hold
  bit       m_rw;
  bit [6:0] m_addr;
  bit [7:0] m_data;
  bit [1:0] m_code;
  int       m_cnt;

  task automatic model_reset();
    m_rw = 0; m_addr = 0; m_data = 0; m_code = 0; m_cnt = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.mosi = w[i];
      tick(4);
      bus.sck = 1'b1;
      tick(4);
      bus.sck = 1'b0;
    end
  endtask

  task automatic check_held(input string pfx);
    chk({pfx, "_rw"},   bus.frame_rw,   m_rw);
    chk({pfx, "_addr"}, bus.frame_addr, m_addr);
    chk({pfx, "_data"}, bus.frame_data, m_data);
    chk({pfx, "_code"}, bus.err_code,   m_code);
    chk({pfx, "_cnt"},  bus.frame_cnt,  m_cnt);
  endtask

  task automatic do_reset(input logic cs_level);
    @(negedge clk);
    rst_n    = 1'b0;
    bus.cs_n = cs_level;
    bus.sck  = 1'b0;
    bus.mosi = 1'b0;
    tick(3);
    chk("rst_outs", {bus.frame_valid, bus.frame_err, bus.frame_rw, bus.frame_addr,
                     bus.frame_data, bus.err_code, bus.frame_cnt}, 32'd0);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic send_frame(input logic [31:0] w, input int n);
    int  lat;
    bit  exp_err;
    ev_t ev;
    @(negedge clk);
    bus.cs_n = 1'b0;
    tick(4);
    shift_bits(w, n);
    tick(4);
    bus.cs_n = 1'b1;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if ((bus.frame_valid || bus.frame_err) && lat < 0) lat = k;
    end
    if (n == 16) begin
      m_rw    = ((w >> 15) & 32'h1) != 0;
      m_addr  = 7'((w >> 8) & 32'h7f);
      m_data  = 8'(w & 32'hff);
      m_cnt   = (m_cnt + 1) % 256;
      exp_err = 1'b0;
    end else begin
      m_code  = (n > 16) ? 2'b10 : 2'b01;
      exp_err = 1'b1;
    end
    chk("latency", lat, SYNC + 2);
    chk("n_pulses", evq.size(), 1);
    if (evq.size() > 0) begin
      ev = evq.pop_front();
      chk("pulse_kind", ev.is_err, exp_err);
      if (exp_err) chk("pulse_code", ev.code, m_code);
      else chk("pulse_word", {ev.rw, ev.addr, ev.data, ev.cnt}, {m_rw, m_addr, m_data, 8'(m_cnt)});
    end
    evq.delete();
    check_held("out");
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.cs_n = 1'b1;
    bus.sck  = 1'b0;
    bus.mosi = 1'b0;
    model_reset();
    do_reset(1'b1);
    tick(10);

    // directed frames
    send_frame(32'h8480, 16);
    chk("t1_addr", bus.frame_addr, 7'h04);
    send_frame(32'($urandom), 12);
    send_frame(32'($urandom), 17);
    send_frame(32'h0155, 16);
    chk("t3_data", bus.frame_data, 8'h55);
    send_frame(32'h0, 0);

    // CS held low through reset release: partial transfer must be ignored
    do_reset(1'b0);
    tick(2);
    shift_bits(32'($urandom), 5);
    tick(4);
    bus.cs_n = 1'b1;
    tick(12);
    chk("arm_pulses", evq.size(), 0);
    check_held("arm");
    send_frame(32'($urandom), 16);

    // reset in the middle of a frame
    @(negedge clk);
    bus.cs_n = 1'b0;
    tick(4);
    shift_bits(32'($urandom), 8);
    do_reset(1'b0);
    tick(3);
    bus.cs_n = 1'b1;
    tick(12);
    chk("midrst_pulses", evq.size(), 0);
    send_frame(32'h82FF, 16);
    chk("t5_addr", bus.frame_addr, 7'h02);
    chk("t5_data", bus.frame_data, 8'hFF);

    // random mix of good and malformed frames
    for (int i = 0; i < 24; i++) begin
      int n;
      n = ($urandom_range(0, 5) < 3) ? 16 : int'($urandom_range(0, 20));
      send_frame(32'($urandom), n);
    end

    // counter wrap after 256 good frames from reset
    do_reset(1'b1);
    tick(10);
    for (int i = 0; i < 256; i++) send_frame(32'($urandom), 16);
    chk("cnt_wrap", bus.frame_cnt, 8'd0);

    chk("valid_err_overlap", both_viol, 0);
    chk("pulse_back_to_back", b2b_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
